// File: rtl/pwl_table_loader_pkg.sv
// pwl_table_loader_pkg
//   Shared definitions for the PWL table loader: loader FSM state encoding,
//   the packed segment word layout, and the table size derivations.
package pwl_table_loader_pkg;

    // Legacy-compatible state codes, also exposed as an enum for the FSM.
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LOAD_SEG  = 2'd1;
    localparam logic [1:0] ST_LOAD_BIAS = 2'd2;
    localparam logic [1:0] ST_COMMIT    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE      = ST_IDLE,
        S_LOAD_SEG  = ST_LOAD_SEG,
        S_LOAD_BIAS = ST_LOAD_BIAS,
        S_COMMIT    = ST_COMMIT
    } loader_state_t;

    // Segment word {offset, slope} at the reference 8/8 configuration.
    localparam int unsigned SEG_OFFSET_WIDTH = 8;
    localparam int unsigned SEG_SLOPE_WIDTH  = 8;

    typedef struct packed {
        logic signed [SEG_OFFSET_WIDTH-1:0] offset;
        logic signed [SEG_SLOPE_WIDTH-1:0]  slope;
    } seg_word_t;

    // Number of segment words across all settings.
    function automatic int unsigned ns_words(input int unsigned sw, input int unsigned aw);
        return 32'd1 << (sw + aw);
    endfunction

    // Number of bias words (one per setting, at least one).
    function automatic int unsigned nb_words(input int unsigned sw);
        return 32'd1 << sw;
    endfunction

    // Bias address width: a single setting still gets a 1-bit address.
    function automatic int unsigned bias_addr_bits(input int unsigned sw);
        return (sw == 0) ? 32'd1 : sw;
    endfunction

endpackage

// File: rtl/pwl_table_loader_if.sv
// pwl_table_loader_if
//   Load-session stream between a table source (master) and the loader (slave).
//   start/in_valid/in_data  : session start pulse and valid/ready word stream
//   in_ready                : loader accepts a word this cycle
//   busy/done/table_valid   : session status, swap pulse, committed-table flag
interface pwl_table_loader_if #(
    parameter int unsigned data_width = 2
);
    logic                  start;
    logic                  in_valid;
    logic                  in_ready;
    logic [data_width-1:0] in_data;
    logic                  busy;
    logic                  done;
    logic                  table_valid;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, busy, done, table_valid
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, busy, done, table_valid
    );
endinterface

// File: rtl/pwl_table_loader_ram.sv
// my_ram_sdp
//   Simple dual-port synchronous RAM: one write port, one registered read port.
//   clk, rst         : clock; rst clears only the read register, not the array
//   we/wr_addr/wr_data : write port
//   rd_addr/rd_data  : one-cycle registered read
//   rd_clr           : load zero into the read register instead of memory data
module my_ram_sdp #(
    parameter int unsigned addr_bits = 1,
    parameter int unsigned data_bits = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [addr_bits-1:0] wr_addr,
    input  logic [data_bits-1:0] wr_data,
    input  logic                 rd_clr,
    input  logic [addr_bits-1:0] rd_addr,
    output logic [data_bits-1:0] rd_data
);
    logic [data_bits-1:0] mem [0:(1<<addr_bits)-1];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         rd_data <= '0;
        else if (rd_clr) rd_data <= '0;
        else             rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/pwl_table_loader.sv
// pwl_table_loader
//   Loads PWL segment and bias tables from a valid/ready stream into the shadow
//   half of double-buffered RAMs, then swaps banks atomically on commit.
//   clk, rst       : clock, asynchronous active-high reset
//   bus (slave)    : start/in_valid/in_ready/in_data stream, busy/done/table_valid
//   seg_rd_addr    : {setting, segment index}; seg_rd_data one cycle later
//   bias_rd_addr   : setting index (ignored for a single setting); bias_rd_data one cycle later
module pwl_table_loader
    import pwl_table_loader_pkg::*;
#(
    parameter int unsigned setting_width = 1,
    parameter int unsigned addr_width    = 1,
    parameter int unsigned offset_width  = 1,
    parameter int unsigned slope_width   = 1,
    parameter int unsigned bias_width    = 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    pwl_table_loader_if.slave                       bus,
    input  logic [setting_width+addr_width-1:0]     seg_rd_addr,
    output logic [offset_width+slope_width-1:0]     seg_rd_data,
    input  logic [bias_addr_bits(setting_width)-1:0] bias_rd_addr,
    output logic [bias_width-1:0]                   bias_rd_data
);
    localparam int unsigned CW = setting_width + addr_width;
    localparam int unsigned BW = bias_addr_bits(setting_width);
    localparam int unsigned DW = offset_width + slope_width;
    localparam int unsigned NS = ns_words(setting_width, addr_width);
    localparam int unsigned NB = nb_words(setting_width);
    localparam logic [CW-1:0] SEG_LAST  = CW'(NS - 1);
    localparam logic [CW-1:0] BIAS_LAST = CW'(NB - 1);

    generate
        if (bias_width > DW) begin : g_bias_width_check
            $error("pwl_table_loader: bias_width must not exceed offset_width+slope_width");
        end
    endgenerate

    loader_state_t state;
    logic [CW-1:0] cnt;
    logic          bank_sel;
    logic          done_q;
    logic          table_valid_q;
    logic          accept;
    logic          seg_we;
    logic          bias_we;
    logic [BW-1:0] bias_idx;

    assign bus.in_ready    = (state == S_LOAD_SEG) || (state == S_LOAD_BIAS);
    assign bus.busy        = (state != S_IDLE);
    assign bus.done        = done_q;
    assign bus.table_valid = table_valid_q;

    // A start in the same cycle as a word aborts the session; the word is dropped.
    assign accept  = bus.in_valid & bus.in_ready & ~bus.start;
    assign seg_we  = accept && (state == S_LOAD_SEG);
    assign bias_we = accept && (state == S_LOAD_BIAS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            bank_sel      <= 1'b0;
            done_q        <= 1'b0;
            table_valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state <= S_LOAD_SEG;
                        cnt   <= '0;
                    end
                end
                S_LOAD_SEG: begin
                    if (bus.start) begin
                        cnt <= '0;
                    end else if (accept) begin
                        if (cnt == SEG_LAST) begin
                            state <= S_LOAD_BIAS;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_LOAD_BIAS: begin
                    if (bus.start) begin
                        state <= S_LOAD_SEG;
                        cnt   <= '0;
                    end else if (accept) begin
                        if (cnt == BIAS_LAST) state <= S_COMMIT;
                        else                  cnt   <= cnt + 1'b1;
                    end
                end
                S_COMMIT: begin
                    bank_sel      <= ~bank_sel;
                    table_valid_q <= 1'b1;
                    done_q        <= 1'b1;
                    state         <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bias_idx = (setting_width == 0) ? '0 : bias_rd_addr;

    // Until the first commit the read bank holds no table, so reads return zero.
    my_ram_sdp #(
        .addr_bits(CW + 1),
        .data_bits(DW)
    ) u_seg_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (seg_we),
        .wr_addr ({~bank_sel, cnt}),
        .wr_data (bus.in_data),
        .rd_clr  (~table_valid_q),
        .rd_addr ({bank_sel, seg_rd_addr}),
        .rd_data (seg_rd_data)
    );

    my_ram_sdp #(
        .addr_bits(BW + 1),
        .data_bits(bias_width)
    ) u_bias_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (bias_we),
        .wr_addr ({~bank_sel, cnt[BW-1:0]}),
        .wr_data (bus.in_data[bias_width-1:0]),
        .rd_clr  (~table_valid_q),
        .rd_addr ({bank_sel, bias_idx}),
        .rd_data (bias_rd_data)
    );
endmodule

// File: tb/tb_pwl_table_loader.sv
module tb_pwl_table_loader;
    import pwl_table_loader_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus sources, index 0 = DUT A (2 settings x 4 segs), 1 = DUT B (1 setting x 4 segs)
    logic        s_start [2];
    logic        s_valid [2];
    logic [15:0] s_data  [2];
    logic [2:0]  seg_addr  [2];
    logic        bias_addr [2];
    logic        rd_req    [2];

    logic [15:0] seg_data_a, seg_data_b;
    logic [7:0]  bias_data_a, bias_data_b;

    pwl_table_loader_if #(.data_width(16)) bus_a ();
    pwl_table_loader_if #(.data_width(16)) bus_b ();

    assign bus_a.start    = s_start[0];
    assign bus_a.in_valid = s_valid[0];
    assign bus_a.in_data  = s_data[0];
    assign bus_b.start    = s_start[1];
    assign bus_b.in_valid = s_valid[1];
    assign bus_b.in_data  = s_data[1];

    pwl_table_loader #(
        .setting_width(1), .addr_width(2), .offset_width(8), .slope_width(8), .bias_width(8)
    ) dut_a (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus_a),
        .seg_rd_addr  (seg_addr[0]),
        .seg_rd_data  (seg_data_a),
        .bias_rd_addr (bias_addr[0]),
        .bias_rd_data (bias_data_a)
    );

    pwl_table_loader #(
        .setting_width(0), .addr_width(2), .offset_width(8), .slope_width(8), .bias_width(8)
    ) dut_b (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus_b),
        .seg_rd_addr  (seg_addr[1][1:0]),
        .seg_rd_data  (seg_data_b),
        .bias_rd_addr (bias_addr[1]),
        .bias_rd_data (bias_data_b)
    );

    // ---------------- reference model ----------------
    int unsigned ns_of [2] = '{8, 4};
    int unsigned nb_of [2] = '{2, 1};
    logic [15:0] m_seg  [2][8];
    logic [7:0]  m_bias [2][2];
    bit          m_valid [2];

    function automatic logic [15:0] exp_seg(input int w, input int a);
        return m_valid[w] ? m_seg[w][a] : 16'h0;
    endfunction

    function automatic logic [7:0] exp_bias(input int w, input int a);
        if (!m_valid[w]) return 8'h0;
        return (w == 1) ? m_bias[1][0] : m_bias[0][a];
    endfunction

    typedef struct {
        logic [15:0] seg;
        logic [7:0]  bias;
    } rd_exp_t;

    typedef struct {
        int unsigned start_cyc;
        int unsigned len;
        bit          exact;
    } done_exp_t;

    rd_exp_t   rq_a [$];
    rd_exp_t   rq_b [$];
    done_exp_t dq_a [$];
    done_exp_t dq_b [$];
    int unsigned done_cnt [2] = '{0, 0};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    function automatic logic get_ready(input int w);
        return (w == 1) ? bus_b.in_ready : bus_a.in_ready;
    endfunction

    task automatic push_rd(input int w, input rd_exp_t e);
        if (w == 1) rq_b.push_back(e);
        else        rq_a.push_back(e);
    endtask

    // ---------------- monitor ----------------
    task automatic compare_read(input int w);
        rd_exp_t e;
        if ((w == 1 ? rq_b.size() : rq_a.size()) == 0) begin
            fail_now("read with no expectation queued");
            return;
        end
        e = (w == 1) ? rq_b.pop_front() : rq_a.pop_front();
        check(w == 1 ? "b_seg_rd_data"  : "a_seg_rd_data",  32'(w == 1 ? seg_data_b  : seg_data_a),  32'(e.seg));
        check(w == 1 ? "b_bias_rd_data" : "a_bias_rd_data", 32'(w == 1 ? bias_data_b : bias_data_a), 32'(e.bias));
    endtask

    task automatic compare_done(input int w);
        done_exp_t e;
        int unsigned diff;
        done_cnt[w]++;
        if ((w == 1 ? dq_b.size() : dq_a.size()) == 0) begin
            fail_now(w == 1 ? "b_unexpected_done" : "a_unexpected_done");
            return;
        end
        e    = (w == 1) ? dq_b.pop_front() : dq_a.pop_front();
        diff = cyc - e.start_cyc;
        if (e.exact) check(w == 1 ? "b_done_latency" : "a_done_latency", diff, e.len);
        else         check(w == 1 ? "b_done_min_latency" : "a_done_min_latency", 32'(diff >= e.len), 32'd1);
    endtask

    initial begin : monitor
        bit sa, sb;
        forever begin
            @(posedge clk);
            sa = rd_req[0];
            sb = rd_req[1];
            @(negedge clk);
            if (sa) compare_read(0);
            if (sb) compare_read(1);
            if (bus_a.done === 1'b1) compare_done(0);
            if (bus_b.done === 1'b1) compare_done(1);
        end
    end

    // ---------------- stimulus tasks (entered just after a negedge) ----------------
    task automatic load(input int w, input logic [15:0] words[$], input int pct,
                        input bit exact, input bit junk_at_start);
        done_exp_t   e;
        int unsigned idx = 0;
        int unsigned guard = 0;
        int unsigned d0;
        bit          v, acc;
        s_start[w] = 1'b1;
        s_valid[w] = junk_at_start;
        s_data[w]  = 16'hDEAD;
        e.start_cyc = cyc;
        e.len       = ns_of[w] + nb_of[w] + 2;
        e.exact     = exact;
        if (w == 1) dq_b.push_back(e);
        else        dq_a.push_back(e);
        d0 = done_cnt[w];
        @(negedge clk);
        s_start[w] = 1'b0;
        while (idx < words.size() && guard < 1000) begin
            v          = ($urandom_range(99) < pct);
            s_valid[w] = v;
            s_data[w]  = v ? words[idx] : 16'($urandom);
            acc        = v && get_ready(w);
            @(negedge clk);
            if (acc) idx++;
            guard++;
        end
        s_valid[w] = 1'b0;
        if (idx < words.size()) fail_now("stream stalled, in_ready never accepted all words");
        guard = 0;
        while (done_cnt[w] == d0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (done_cnt[w] == d0) begin
            fail_now("done timeout");
        end else begin
            for (int unsigned i = 0; i < ns_of[w]; i++) m_seg[w][i] = words[i];
            for (int unsigned i = 0; i < nb_of[w]; i++) m_bias[w][i] = words[ns_of[w] + i][7:0];
            m_valid[w] = 1'b1;
        end
    endtask

    task automatic read_all(input int w);
        rd_exp_t e;
        for (int a = 0; a < int'(ns_of[w]); a++) begin
            seg_addr[w]  = 3'(a);
            bias_addr[w] = 1'($urandom_range(1));
            e.seg  = exp_seg(w, a);
            e.bias = exp_bias(w, int'(bias_addr[w]));
            push_rd(w, e);
            rd_req[w] = 1'b1;
            @(negedge clk);
        end
        rd_req[w] = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},        32'(bus_a.busy),        32'd0);
        check({tag, "_in_ready"},    32'(bus_a.in_ready),    32'd0);
        check({tag, "_done"},        32'(bus_a.done),        32'd0);
        check({tag, "_table_valid"}, 32'(bus_a.table_valid), 32'd0);
        check({tag, "_seg_rd_data"}, 32'(seg_data_a),        32'd0);
        check({tag, "_bias_rd_data"},32'(bias_data_a),       32'd0);
    endtask

    // ---------------- main sequence ----------------
    logic [15:0] wq [$];
    logic [15:0] old_seg  [8];
    logic [7:0]  old_bias [2];
    seg_word_t   sw;
    int unsigned dc0;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        for (int i = 0; i < 2; i++) begin
            s_start[i] = 1'b0; s_valid[i] = 1'b0; s_data[i] = '0;
            seg_addr[i] = '0; bias_addr[i] = 1'b0; rd_req[i] = 1'b0;
            m_valid[i] = 1'b0;
        end
        rst = 1'b0;
        #1 rst = 1'b1;
        #11;
        check_idle_outputs("reset");
        check("b_reset_table_valid", 32'(bus_b.table_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // No load yet: reads stay zero.
        read_all(0);

        // Full load: segments 0x0100..0x0107, biases 0x11, 0x22.
        wq = {};
        for (int i = 0; i < 8; i++) begin
            sw.offset = 8'h01;
            sw.slope  = 8'(i);
            wq.push_back(sw);
        end
        wq.push_back(16'h0011);
        wq.push_back(16'h0022);
        load(0, wq, 100, 1'b1, 1'b0);
        check("a_table_valid_after_load", 32'(bus_a.table_valid), 32'd1);
        check("a_busy_after_load",        32'(bus_a.busy),        32'd0);
        read_all(0);

        // Atomic swap: reads every cycle across the session and the swap edge.
        foreach (old_seg[i])  old_seg[i]  = m_seg[0][i];
        foreach (old_bias[i]) old_bias[i] = m_bias[0][i];
        wq = {};
        for (int i = 0; i < 8; i++) wq.push_back(16'h0200 + 16'(i));
        wq.push_back(16'h0033);
        wq.push_back(16'h0044);
        fork
            load(0, wq, 100, 1'b1, 1'b0);
            begin
                rd_exp_t e;
                int unsigned a, b;
                for (int j = 0; j < 16; j++) begin
                    a = $urandom_range(7);
                    b = $urandom_range(1);
                    seg_addr[0]  = 3'(a);
                    bias_addr[0] = 1'(b);
                    // Sampled at edge start+j+1; the swap edge is start+12.
                    e.seg  = (j >= 12) ? wq[a] : old_seg[a];
                    e.bias = (j >= 12) ? wq[8 + b][7:0] : old_bias[b];
                    push_rd(0, e);
                    rd_req[0] = 1'b1;
                    @(negedge clk);
                end
                rd_req[0] = 1'b0;
            end
        join
        @(negedge clk);
        @(negedge clk);
        read_all(0);

        // Backpressure: random words, in_valid toggled at 50%.
        wq = {};
        for (int i = 0; i < 10; i++) wq.push_back(16'($urandom));
        load(0, wq, 50, 1'b0, 1'b0);
        read_all(0);

        // Abort: start, 3 words, then restart (junk word coinciding with start).
        dc0 = done_cnt[0];
        s_start[0] = 1'b1;
        @(negedge clk);
        s_start[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid[0] = 1'b1;
            s_data[0]  = 16'hA000 + 16'(i);
            @(negedge clk);
        end
        wq = {};
        for (int i = 0; i < 10; i++) wq.push_back(16'($urandom));
        load(0, wq, 100, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check("a_abort_done_count", done_cnt[0] - dc0, 32'd1);
        read_all(0);

        // Reset in the middle of a session.
        s_start[0] = 1'b1;
        @(negedge clk);
        s_start[0] = 1'b0;
        s_valid[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data[0] = 16'($urandom);
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        check_idle_outputs("midreset");
        s_valid[0] = 1'b0;
        m_valid[0] = 1'b0;
        m_valid[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        read_all(0);

        // Single-setting instance: 4 segments and 1 bias.
        wq = {};
        for (int i = 0; i < 5; i++) wq.push_back(16'($urandom));
        load(1, wq, 100, 1'b1, 1'b0);
        check("b_table_valid_after_load", 32'(bus_b.table_valid), 32'd1);
        read_all(1);

        repeat (4) @(negedge clk);
        check("a_pending_done", dq_a.size(), 32'd0);
        check("b_pending_done", dq_b.size(), 32'd0);
        check("a_pending_reads", rq_a.size(), 32'd0);
        check("b_pending_reads", rq_b.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pwl_table_loader.md
# pwl_table_loader

Writer side of the piecewise-linear (PWL) function tables. It accepts a valid/ready stream of segment words (packed offset and slope) and bias words, and writes them into a double-buffered table RAM. On commit it swaps that RAM atomically into the read side. The read side exposes the same one-cycle synchronous read behaviour as the fixed segment and bias ROMs, so the PWL evaluator can be retargeted at runtime and never sees a partially written table.

## Interface
Parameters:
- setting_width, 1: bits of setting index; 0 means a single setting.
- addr_width, 1: segment address bits per setting.
- offset_width, 1: segment offset width, signed, point = evaluator out_point.
- slope_width, 1: segment slope width, signed.
- bias_width, 1: bias width, signed. Must be ≤ offset_width+slope_width, otherwise `$error` at elaboration.

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load session.
- in_valid  in  1  stream word valid.
- in_ready  out  1  loader accepts a word this cycle.
- in_data  in  offset_width+slope_width  segment word {offset, slope}; a bias word occupies the low bias_width bits.
- busy  out  1  high while a session is in progress.
- done  out  1  one-cycle pulse in the cycle the bank swap takes effect.
- table_valid  out  1  at least one commit has completed since reset.
- seg_rd_addr  in  setting_width+addr_width  {setting, segment index}.
- seg_rd_data  out  offset_width+slope_width  registered read data.
- bias_rd_addr  in  max(setting_width,1)  setting index; ignored when setting_width=0.
- bias_rd_data  out  bias_width  registered read data.

## Operation
- Definitions: NS = 2^(setting_width+addr_width) segment words; NB = 2^setting_width bias words (NB = 1 when setting_width = 0).
- Two RAM banks each for segments and biases. bank_sel selects the read bank; writes always go to bank ~bank_sel.
- FSM states:
  - IDLE: in_ready=0. start → LOAD_SEG, counter cleared.
  - LOAD_SEG: in_ready=1. Each accepted word (in_valid & in_ready) writes the shadow segment RAM at address = counter, then counter increments. After accepting word NS-1 → LOAD_BIAS, counter cleared.
  - LOAD_BIAS: in_ready=1. Each accepted word writes in_data[bias_width-1:0] to the shadow bias RAM at address = counter. After accepting word NB-1 → COMMIT.
  - COMMIT: in_ready=0. One cycle only; toggles bank_sel, sets table_valid, pulses done → IDLE.
- Write order is linear: setting-major, segment index minor. This matches the {setting, index} read address.
- start during LOAD_SEG or LOAD_BIAS aborts the session and restarts at LOAD_SEG with counter 0. The shadow contents are discarded; bank_sel is unchanged. If start coincides with an accepted word, start wins and the word is not written.
- start during COMMIT is ignored.
- in_valid in IDLE or COMMIT is ignored (in_ready=0).
- busy = (state != IDLE).
- Reset state: IDLE, counter 0, bank_sel 0, in_ready 0, busy 0, done 0, table_valid 0, seg_rd_data 0, bias_rd_data 0. RAM contents are not reset.
- Reset mid-session aborts the session. The bank written so far is discarded; table_valid returns to 0.

## Timing
- Read latency is 1 cycle. An address sampled at edge t presents its data after t, read from the bank_sel value held before edge t.
- Swap: bank_sel toggles at the edge ending COMMIT, and done is high in the following cycle. A read sampled at that same edge returns the old bank; all later reads return the new bank.
- Minimum session length is NS+NB+2 cycles from start to done, with in_valid held high.
- Backpressure is free: in_valid may drop at any time, and the counter holds.
- Same-address read/write hazards cannot occur, because reads and writes always target different banks.

## Structure
- Shared package: the segment word typedef {offset, slope}, the loader FSM state enum, and the NS/NB derivation functions.
- One sub-module, `my_ram_sdp`: simple dual-port synchronous RAM with 1 write port and 1 read port, parameters addr_bits and data_bits. Instantiate two of it: segments with addr_bits = setting_width+addr_width+1, biases with addr_bits = max(setting_width,1)+1. The top address bit is the bank.

## Test plan
- Reset check: with rst high asynchronously mid-cycle, all outputs go to 0 immediately and table_valid=0. With no load, seg_rd_data stays 0.
- Full load (setting_width=1, addr_width=2, offset_width=8, slope_width=8, bias_width=8):
  - Stimulus: start, then segment words 0x0100..0x0107 and bias words 0x11, 0x22 with in_valid held high.
  - Required: done exactly 12 cycles after the start pulse; table_valid=1.
  - Reads: seg_rd_addr=5 → 0x0105; bias_rd_addr=1 → 0x22.
- Atomic swap: after the first load, start a second load of 0x0200..0x0207 with 0x33/0x44. Reads during the load still return 0x01xx. A read sampled at the commit edge returns old data; the next read returns 0x02xx.
- Backpressure: toggle in_valid randomly (50%). Final contents match the in-order stream; the session takes at least 12 cycles; no word is lost or duplicated.
- Abort: start, 3 words, start again, then a full 10-word load. Address 0 holds the first word of the second stream, and done pulses once.
- setting_width=0, addr_width=2: 4 segment words and 1 bias word. done pulses 7 cycles after start; bias_rd_addr is ignored.
